add_path_scheduler: RTL and testbench
=====================================

// Module: add_path_scheduler
// PURPOSE
//  Front-end sequencer for the dual-path FP adder. Accepts one operation per cycle over a valid/ready
//  handshake and classifies it as close path (effective subtract, |Ea-Eb|<2) or far path. Issues it
//  to the fixed-latency close or far datapath, and returns the muxed result in strict issue order.
//  Stalls only when issuing would break ordering or make two completions collide.
// PARAMETERS
//  SIZE_EXPONENT   8   exponent width
//  SIZE_MANTISSA   24  result mantissa width (1.M)
//  CLOSE_LAT       2   close-path latency, issue to result valid (>=1)
//  FAR_LAT         3   far-path latency, issue to result valid (>=1)
//  TAG_W           4   requester tag width
//  CNT_W           4   remain-counter width, 2**CNT_W > max(CLOSE_LAT,FAR_LAT)
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous reset, active-high
//  in_valid     in   1              operation offered
//  in_ready     out  1              operation accepted when in_valid&&in_ready
//  in_sign_a/b  in   1              operand signs
//  in_sub       in   1              1 = A-B, 0 = A+B
//  in_e_a/in_e_b in  SIZE_EXPONENT  operand exponents
//  in_tag       in   TAG_W          opaque tag, returned with the result
//  close_go     out  1              one-cycle issue strobe to close path
//  far_go       out  1              one-cycle issue strobe to far path
//  iss_eff_op   out  1              effective op of the issued operation (1 = subtract)
//  close_m/e    in   SIZE_MANTISSA/SIZE_EXPONENT  close-path result, valid CLOSE_LAT after close_go
//  far_m/e      in   SIZE_MANTISSA/SIZE_EXPONENT  far-path result, valid FAR_LAT after far_go
//  out_valid    out  1              result strobe (no backpressure)
//  out_m/out_e  out  SIZE_MANTISSA/SIZE_EXPONENT  registered result
//  out_tag      out  TAG_W          tag of the result
// BEHAVIOUR
//  - Reset: in_ready=1, close_go=far_go=iss_eff_op=0, out_valid=0, out_m/out_e/out_tag=0.
//    Hold register, remain counter and completion pipe cleared. Reset mid-operation discards in-flight work.
//  - Classification on accept: eff_op = sign_a ^ sign_b ^ sub.
//    close = eff_op && (|e_a-e_b| <= 1), using unsigned compare-subtract on SIZE_EXPONENT bits.
//    The hold register captures {close, eff_op, tag}.
//  - FSM: EMPTY -> HELD on accept. HELD -> EMPTY on issue with no new accept.
//    HELD -> HELD on issue plus accept in the same cycle.
//    in_ready = (state==EMPTY) || issue.
//  - Issue rule: L = close ? CLOSE_LAT : FAR_LAT. issue = HELD && (L > remain).
//    remain = cycles until the last issued result is valid; 0 when idle.
//    On issue: remain <= L-1. Otherwise: remain <= remain-1, saturating at 0.
//    This guarantees strictly increasing completion times: in order, no collisions.
//  - Minimum latency: accept at t -> go at t+1 -> datapath result at t+1+L -> out_valid at t+2+L.
//  - Completion pipe: depth max(CLOSE_LAT,FAR_LAT), entries {vld, sel, tag}.
//    On issue, the entry is written at slot L-1; the pipe shifts each cycle.
//    At slot 0 with vld, out_* <= sel ? close_* : far_*, out_valid <= 1. Otherwise out_valid <= 0.
//    out_m/out_e/out_tag hold their last value while out_valid=0.
//  - Back-to-back issue of the same path is allowed every cycle (remain=L-1 < L).
// CONFIGURATION
//  ADD_PATH_STATS_EN defined: adds outputs stat_close, stat_far, stat_stall (16 bits each, saturating).
//    They count close issues, far issues, and cycles spent HELD without issue. All are cleared by rst.
//  ADD_PATH_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package: path-select encoding (PATH_FAR=0, PATH_CLOSE=1), completion-entry struct
//    {vld,sel,tag}, and a function computing the max latency.
//  - One sub-module, add_path_classify: combinational eff_op/close decision.
//  - Hold register, counter, completion pipe and output register live in the top level.
// TESTING (CLOSE_LAT=2, FAR_LAT=3)
//  1. Close path: signs 0/1, add, e_a=0x80, e_b=0x81 at t.
//     -> close_go@t+1, iss_eff_op=1, out_valid@t+4 with out_m/out_e = close_m/close_e.
//  2. Far path, exponent gap: e_a=0x80, e_b=0x82, subtract, same signs.
//     -> far_go@t+1, out_valid@t+5 with far result.
//  3. Effective add, equal exponents: signs 0/0, add, e_a=e_b=0x7F. -> far_go, iss_eff_op=0.
//  4. Ordering stall: far op at t, close op at t+1.
//     -> far_go@t+1; in_ready=0 @t+2; close_go@t+3.
//     -> outputs at t+5 (far tag) then t+6 (close tag); never two in one cycle.
//  5. Streaming: 8 close ops on consecutive cycles.
//     -> in_ready stays 1, 8 out_valid pulses on consecutive cycles, tags in order.
//  6. Reset mid-flight: assert rst one cycle after a far_go.
//     -> all outputs 0 immediately; no out_valid after deassertion; in_ready=1.

Source files
------------

// File: rtl/add_path_scheduler_pkg.sv
// Shared types for the dual-path FP adder front-end: path-select encoding,
// completion-pipe entry and the max-latency helper.
package add_path_scheduler_pkg;

    localparam int unsigned APS_TAG_W = 4;

    typedef enum logic {
        PATH_FAR   = 1'b0,
        PATH_CLOSE = 1'b1
    } path_sel_e;

    // Tag field width is fixed here; the top-level TAG_W must match APS_TAG_W.
    typedef struct packed {
        logic                 vld;
        path_sel_e            sel;
        logic [APS_TAG_W-1:0] tag;
    } cpl_entry_t;

    function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/add_path_scheduler_if.sv
// Issue/result bus between the adder front-end sequencer and its requester/datapaths.
interface add_path_scheduler_if #(
    parameter int unsigned SIZE_EXPONENT = 8,
    parameter int unsigned SIZE_MANTISSA = 24,
    parameter int unsigned TAG_W         = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign_a;
    logic                     in_sign_b;
    logic                     in_sub;
    logic [SIZE_EXPONENT-1:0] in_e_a;
    logic [SIZE_EXPONENT-1:0] in_e_b;
    logic [TAG_W-1:0]         in_tag;
    logic                     close_go;
    logic                     far_go;
    logic                     iss_eff_op;
    logic [SIZE_MANTISSA-1:0] close_m;
    logic [SIZE_EXPONENT-1:0] close_e;
    logic [SIZE_MANTISSA-1:0] far_m;
    logic [SIZE_EXPONENT-1:0] far_e;
    logic                     out_valid;
    logic [SIZE_MANTISSA-1:0] out_m;
    logic [SIZE_EXPONENT-1:0] out_e;
    logic [TAG_W-1:0]         out_tag;

    modport slave (
        input  in_valid, in_sign_a, in_sign_b, in_sub, in_e_a, in_e_b, in_tag,
        input  close_m, close_e, far_m, far_e,
        output in_ready, close_go, far_go, iss_eff_op,
        output out_valid, out_m, out_e, out_tag
    );

    modport master (
        output in_valid, in_sign_a, in_sign_b, in_sub, in_e_a, in_e_b, in_tag,
        output close_m, close_e, far_m, far_e,
        input  in_ready, close_go, far_go, iss_eff_op,
        input  out_valid, out_m, out_e, out_tag
    );
endinterface

// File: rtl/add_path_scheduler_classify.sv
// Combinational close/far decision: close = effective subtract with |Ea-Eb| <= 1.
module add_path_classify #(
    parameter int unsigned SIZE_EXPONENT = 8
) (
    input  logic                     i_sign_a,
    input  logic                     i_sign_b,
    input  logic                     i_sub,
    input  logic [SIZE_EXPONENT-1:0] i_e_a,
    input  logic [SIZE_EXPONENT-1:0] i_e_b,
    output logic                     o_eff_op,
    output logic                     o_close
);
    logic [SIZE_EXPONENT-1:0] w_diff;

    always_comb begin
        w_diff   = (i_e_a >= i_e_b) ? (i_e_a - i_e_b) : (i_e_b - i_e_a);
        o_eff_op = i_sign_a ^ i_sign_b ^ i_sub;
        o_close  = o_eff_op && (w_diff <= SIZE_EXPONENT'(1));
    end
endmodule

// File: rtl/add_path_scheduler.sv
// In-order issue sequencer for the dual-path FP adder (close/far fixed-latency paths).
// Optional ADD_PATH_STATS_EN adds saturating close/far/stall counters.
module add_path_scheduler
    import add_path_scheduler_pkg::*;
#(
    parameter int unsigned SIZE_EXPONENT = 8,
    parameter int unsigned SIZE_MANTISSA = 24,
    parameter int unsigned CLOSE_LAT     = 2,
    parameter int unsigned FAR_LAT       = 3,
    parameter int unsigned TAG_W         = APS_TAG_W,
    parameter int unsigned CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    add_path_scheduler_if.slave bus
`ifdef ADD_PATH_STATS_EN
    ,
    output logic [15:0]       stat_close,
    output logic [15:0]       stat_far,
    output logic [15:0]       stat_stall
`endif
);
    localparam int unsigned PIPE_D = max_lat(CLOSE_LAT, FAR_LAT);
    localparam logic [CNT_W-1:0] LAT_CLOSE = CNT_W'(CLOSE_LAT);
    localparam logic [CNT_W-1:0] LAT_FAR   = CNT_W'(FAR_LAT);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HELD  = 1'b1;

    logic [0:0]       r_state;
    logic             r_hold_close;
    logic             r_hold_eff;
    logic [TAG_W-1:0] r_hold_tag;
    logic [CNT_W-1:0] r_remain;
    cpl_entry_t       r_pipe [PIPE_D];
    cpl_entry_t       w_pipe_nxt [PIPE_D];
    cpl_entry_t       w_new;

    logic             w_eff_op;
    logic             w_close;
    logic [CNT_W-1:0] w_lat;
    logic             w_issue;
    logic             w_accept;

    add_path_classify #(.SIZE_EXPONENT(SIZE_EXPONENT)) u_classify (
        .i_sign_a (bus.in_sign_a),
        .i_sign_b (bus.in_sign_b),
        .i_sub    (bus.in_sub),
        .i_e_a    (bus.in_e_a),
        .i_e_b    (bus.in_e_b),
        .o_eff_op (w_eff_op),
        .o_close  (w_close)
    );

    // Issuing only when L > remain keeps completion times strictly increasing.
    assign w_lat    = r_hold_close ? LAT_CLOSE : LAT_FAR;
    assign w_issue  = (r_state == S_HELD) && (w_lat > r_remain);
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = (r_state == S_EMPTY) || w_issue;
    assign bus.close_go   = w_issue && r_hold_close;
    assign bus.far_go     = w_issue && !r_hold_close;
    assign bus.iss_eff_op = w_issue && r_hold_eff;

    always_comb begin
        w_new.vld = 1'b1;
        w_new.sel = r_hold_close ? PATH_CLOSE : PATH_FAR;
        w_new.tag = r_hold_tag;
        w_pipe_nxt[PIPE_D-1] = '0;
        for (int unsigned i = 0; i + 1 < PIPE_D; i++) begin
            w_pipe_nxt[i] = r_pipe[i+1];
        end
        for (int unsigned i = 0; i < PIPE_D; i++) begin
            if (w_issue && (CNT_W'(i) == w_lat - 1'b1)) begin
                w_pipe_nxt[i] = w_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_hold_close <= 1'b0;
            r_hold_eff   <= 1'b0;
            r_hold_tag   <= '0;
            r_remain     <= '0;
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_state      <= S_HELD;
                r_hold_close <= w_close;
                r_hold_eff   <= w_eff_op;
                r_hold_tag   <= bus.in_tag;
            end else if (w_issue) begin
                r_state <= S_EMPTY;
            end
            if (w_issue) begin
                r_remain <= w_lat - 1'b1;
            end else if (r_remain != '0) begin
                r_remain <= r_remain - 1'b1;
            end
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                r_pipe[i] <= w_pipe_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_m     <= '0;
            bus.out_e     <= '0;
            bus.out_tag   <= '0;
        end else begin
            bus.out_valid <= r_pipe[0].vld;
            if (r_pipe[0].vld) begin
                bus.out_m   <= (r_pipe[0].sel == PATH_CLOSE) ? bus.close_m : bus.far_m;
                bus.out_e   <= (r_pipe[0].sel == PATH_CLOSE) ? bus.close_e : bus.far_e;
                bus.out_tag <= r_pipe[0].tag;
            end
        end
    end

`ifdef ADD_PATH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_close <= '0;
            stat_far   <= '0;
            stat_stall <= '0;
        end else begin
            if (bus.close_go && (stat_close != '1)) stat_close <= stat_close + 16'd1;
            if (bus.far_go && (stat_far != '1))     stat_far   <= stat_far + 16'd1;
            if ((r_state == S_HELD) && !w_issue && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_path_scheduler.sv
// Directed bench for add_path_scheduler (CLOSE_LAT=2, FAR_LAT=3); datapaths modelled
// as cycle-indexed constants so each result identifies the cycle it was sampled in.
module tb_add_path_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    add_path_scheduler_if #(.SIZE_EXPONENT(8), .SIZE_MANTISSA(24), .TAG_W(4)) bus ();

`ifdef ADD_PATH_STATS_EN
    logic [15:0] stat_close, stat_far, stat_stall;
`endif

    add_path_scheduler #(
        .SIZE_EXPONENT(8), .SIZE_MANTISSA(24), .CLOSE_LAT(2), .FAR_LAT(3), .TAG_W(4), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ADD_PATH_STATS_EN
        ,
        .stat_close (stat_close),
        .stat_far   (stat_far),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] cm(input int unsigned c); return 24'hC00000 + 24'(c); endfunction
    function automatic logic [7:0]  ce(input int unsigned c); return 8'(c) ^ 8'hA5; endfunction
    function automatic logic [23:0] fm(input int unsigned c); return 24'hF00000 + 24'(c); endfunction
    function automatic logic [7:0]  fe(input int unsigned c); return 8'(c) ^ 8'h5A; endfunction

    assign bus.close_m = cm(cyc);
    assign bus.close_e = ce(cyc);
    assign bus.far_m   = fm(cyc);
    assign bus.far_e   = fe(cyc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sa, input logic sb, input logic sub,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_sign_a = sa;
        bus.in_sign_b = sb;
        bus.in_sub    = sub;
        bus.in_e_a    = ea;
        bus.in_e_b    = eb;
        bus.in_tag    = tag;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [23:0] m,
                           input logic [7:0] e, input logic [3:0] tag);
        chk({name, "_vld"}, 32'(bus.out_valid), 32'(v));
        chk({name, "_m"},   32'(bus.out_m),     32'(m));
        chk({name, "_e"},   32'(bus.out_e),     32'(e));
        chk({name, "_tag"}, 32'(bus.out_tag),   32'(tag));
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick;
    endtask

    initial begin
        int unsigned t0;
        bus.in_valid = 1'b0; bus.in_sign_a = 1'b0; bus.in_sign_b = 1'b0; bus.in_sub = 1'b0;
        bus.in_e_a = '0; bus.in_e_b = '0; bus.in_tag = '0;
        tick; tick;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cgo", 32'(bus.close_go), 32'd0);
        chk("rst_fgo", 32'(bus.far_go), 32'd0);
        chk("rst_eff", 32'(bus.iss_eff_op), 32'd0);
        chk_out("rst_out", 1'b0, 24'h0, 8'h0, 4'h0);
        rst = 1'b0;
        tick;

        // 1: close path
        drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h81, 4'h1);
        chk("t1_ready", 32'(bus.in_ready), 32'd1);
        t0 = cyc;
        tick; idle;
        chk("t1_cgo", 32'(bus.close_go), 32'd1);
        chk("t1_fgo", 32'(bus.far_go), 32'd0);
        chk("t1_eff", 32'(bus.iss_eff_op), 32'd1);
        tick; chk("t1_v2", 32'(bus.out_valid), 32'd0);
        tick; chk("t1_v3", 32'(bus.out_valid), 32'd0);
        tick; chk_out("t1_out", 1'b1, cm(t0 + 3), ce(t0 + 3), 4'h1);
        tick; chk_out("t1_hold", 1'b0, cm(t0 + 3), ce(t0 + 3), 4'h1);
        drain(3);

        // 2: far path, exponent gap 2
        drive(1'b0, 1'b0, 1'b1, 8'h80, 8'h82, 4'h2);
        t0 = cyc;
        tick; idle;
        chk("t2_fgo", 32'(bus.far_go), 32'd1);
        chk("t2_cgo", 32'(bus.close_go), 32'd0);
        chk("t2_eff", 32'(bus.iss_eff_op), 32'd1);
        drain(3);
        chk("t2_v4", 32'(bus.out_valid), 32'd0);
        tick; chk_out("t2_out", 1'b1, fm(t0 + 4), fe(t0 + 4), 4'h2);
        drain(3);

        // 3: effective add, equal exponents
        drive(1'b0, 1'b0, 1'b0, 8'h7F, 8'h7F, 4'h3);
        t0 = cyc;
        tick; idle;
        chk("t3_fgo", 32'(bus.far_go), 32'd1);
        chk("t3_cgo", 32'(bus.close_go), 32'd0);
        chk("t3_eff", 32'(bus.iss_eff_op), 32'd0);
        drain(4);
        chk_out("t3_out", 1'b1, fm(t0 + 4), fe(t0 + 4), 4'h3);
        drain(3);

        // 4: far then close back-to-back forces a stall
        drive(1'b0, 1'b0, 1'b1, 8'h80, 8'h82, 4'h4);
        t0 = cyc;
        tick;
        drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h81, 4'h5);
        chk("t4_fgo", 32'(bus.far_go), 32'd1);
        chk("t4_rdy1", 32'(bus.in_ready), 32'd1);
        tick; idle;
        chk("t4_rdy2", 32'(bus.in_ready), 32'd0);
        chk("t4_cgo2", 32'(bus.close_go), 32'd0);
        tick; chk("t4_cgo3", 32'(bus.close_go), 32'd1);
        tick; chk("t4_v4", 32'(bus.out_valid), 32'd0);
        tick; chk_out("t4_far", 1'b1, fm(t0 + 4), fe(t0 + 4), 4'h4);
        tick; chk_out("t4_close", 1'b1, cm(t0 + 5), ce(t0 + 5), 4'h5);
        tick; chk("t4_v7", 32'(bus.out_valid), 32'd0);
        drain(3);

        // 5: 8 close ops streaming
        t0 = cyc;
        for (int unsigned k = 0; k < 14; k++) begin
            if (k < 8) begin
                drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h11, 4'(k + 8));
                chk("t5_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                idle;
            end
            if (k >= 4 && k < 12) begin
                chk_out("t5_out", 1'b1, cm(t0 + k - 1), ce(t0 + k - 1), 4'(k + 4));
            end else begin
                chk("t5_quiet", 32'(bus.out_valid), 32'd0);
            end
            tick;
        end
        drain(2);

        // 6: reset one cycle after far_go
        drive(1'b0, 1'b0, 1'b1, 8'h80, 8'h82, 4'h6);
        tick; idle;
        chk("t6_fgo", 32'(bus.far_go), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        chk("t6_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_fgo0", 32'(bus.far_go), 32'd0);
        chk("t6_cgo0", 32'(bus.close_go), 32'd0);
        chk_out("t6_rst", 1'b0, 24'h0, 8'h0, 4'h0);
        tick;
        rst = 1'b0;
        for (int unsigned k = 0; k < 6; k++) begin
            tick;
            chk("t6_novld", 32'(bus.out_valid), 32'd0);
            chk("t6_rdy", 32'(bus.in_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
